// File: rtl/fifo_serial_tx.sv
// Purpose: drains a FIFO one word at a time onto a single-wire async serial line (start, W data bits LSB-first, stop).
// Latency: pop strobe one cycle after en&&!fifo_empty is sampled in IDLE; tx falls two cycles after the pop cycle.
// Backpressure: paced only by bit timing; pops at most one word per frame and never while the FIFO reads empty.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   en              transmit enable, sampled only in IDLE
//   fifo_empty      FIFO empty flag, sampled only in IDLE
//   fifo_dout       FIFO read data, valid the cycle after the pop strobe
//   fifo_rd_en      registered one-cycle pop strobe
//   tx              registered serial line, idle high
//   busy            high from the pop cycle through the last stop-bit cycle
//   frame_done      one-cycle pulse in the first IDLE cycle after a frame
module fifo_serial_tx #(
  parameter int W            = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         fifo_empty,
  input  logic [W-1:0] fifo_dout,
  output logic         fifo_rd_en,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int IW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(W - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAP   = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   shift_q, shift_d;
  logic           tx_d, rd_en_d, busy_d, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx         <= tx_d;
      fifo_rd_en <= rd_en_d;
      busy       <= busy_d;
      frame_done <= done_d;
    end
  end

  // Outputs are derived from the next state so that, once registered, they
  // line up exactly with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (en && !fifo_empty) state_d = RD;
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        // FIFO popped at the previous edge, so fifo_dout now holds the word.
        shift_d = fifo_dout;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d   = idx_q + IW'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    tx_d    = 1'b1;
    if (state_d == START) tx_d = 1'b0;
    if (state_d == DATA)  tx_d = shift_d[0];
    rd_en_d = (state_d == RD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_q == STOP) && (state_d == IDLE);
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

  localparam int W = 4;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [3:0] fifo_dout = 4'h0;
  logic       fifo_rd_en, tx, busy, frame_done;

  // Second instance exercising one-cycle bits.
  logic       en1;
  logic       empty1;
  logic [3:0] dout1 = 4'h0;
  logic       rd1, tx1, busy1, done1;

  int tests = 0;
  int fails = 0;

  // Behavioural FIFO: writer is the stimulus process, reader is the pop strobe.
  logic [3:0] mem [0:15];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic       underflow = 1'b0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  logic [3:0] word1 = 4'h0;
  int         wr1 = 0;
  int         rd1_cnt = 0;
  assign empty1 = (wr1 == rd1_cnt);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wr_cnt == rd_cnt) underflow <= 1'b1;
      else begin
        fifo_dout <= mem[rd_cnt % 16];
        rd_cnt    <= rd_cnt + 1;
      end
    end
    if (rd1 && (wr1 != rd1_cnt)) begin
      dout1   <= word1;
      rd1_cnt <= rd1_cnt + 1;
    end
  end

  fifo_serial_tx #(.W(W), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  fifo_serial_tx #(.W(W), .CLKS_PER_BIT(1)) dut_c1 (
    .clk(clk), .rst(rst), .en(en1), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_rd_en(rd1), .tx(tx1), .busy(busy1), .frame_done(done1)
  );

  // Per-cycle capture of the main instance, sampled on the falling edge.
  logic tx_log [0:511];
  int   rd_pulses, done_pulses, busy_cyc, tx_low, done_idx;
  logic rd_double;

  task automatic push(input logic [3:0] v);
    mem[wr_cnt % 16] = v;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic capture(input int n, input int en_off_at);
    logic prev_rd;
    prev_rd = 1'b0;
    rd_pulses = 0; done_pulses = 0; busy_cyc = 0; tx_low = 0; done_idx = -1; rd_double = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_log[i] = tx;
      if (!tx) tx_low++;
      if (fifo_rd_en) rd_pulses++;
      if (fifo_rd_en && prev_rd) rd_double = 1'b1;
      prev_rd = fifo_rd_en;
      if (frame_done) begin
        done_pulses++;
        if (done_idx < 0) done_idx = i;
      end
      if (busy) busy_cyc++;
      if (i == en_off_at) en = 1'b0;
    end
  endtask

  function automatic logic [3:0] decode(input int s);
    logic [3:0] w;
    for (int b = 0; b < 4; b++) w[b] = tx_log[s + (1 + b) * C + C / 2];
    return w;
  endfunction

  function automatic int run_high(input int from);
    int k;
    k = 0;
    while ((from + k) < 512 && tx_log[from + k] === 1'b1) k++;
    return k;
  endfunction

  function automatic int first_low(input int n);
    for (int i = 0; i < n; i++) if (tx_log[i] === 1'b0) return i;
    return -1;
  endfunction

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; en1 = 1'b0;
    push(4'hA);
    capture(10, -1);
    tests++; if (tx_low !== 0)      begin fails++; $display("FAIL reset_tx: low cycles %0d expected 0", tx_low); end
    tests++; if (rd_pulses !== 0)   begin fails++; $display("FAIL reset_rd_en: pulses %0d expected 0", rd_pulses); end
    tests++; if (busy_cyc !== 0)    begin fails++; $display("FAIL reset_busy: cycles %0d expected 0", busy_cyc); end
    tests++; if (done_pulses !== 0) begin fails++; $display("FAIL reset_done: pulses %0d expected 0", done_pulses); end
    tests++; if ((wr_cnt - rd_cnt) !== 1) begin fails++; $display("FAIL reset_no_pop: fill %0d expected 1", wr_cnt - rd_cnt); end
  endtask

  task automatic test_single_word;
    int s;
    logic [23:0] obs;
    rst = 1'b1;
    capture(40, -1);
    s = first_low(40);
    for (int k = 0; k < 24; k++) obs[k] = tx_log[(s < 0 ? 0 : s) + k];
    tests++; if (rd_pulses !== 1) begin fails++; $display("FAIL single_rd_en: pulses %0d expected 1", rd_pulses); end
    tests++; if (s !== 2)         begin fails++; $display("FAIL single_latency: start index %0d expected 2", s); end
    tests++; if (obs !== 24'hFF0F00) begin fails++; $display("FAIL single_frame: tx %h expected ff0f00", obs); end
    tests++; if (tx_log[26] !== 1'b1) begin fails++; $display("FAIL single_idle_after: tx %b expected 1", tx_log[26]); end
    tests++; if (busy_cyc !== 26) begin fails++; $display("FAIL single_busy: cycles %0d expected 26", busy_cyc); end
    tests++; if (done_pulses !== 1 || done_idx !== 26) begin fails++; $display("FAIL single_done: pulses %0d at %0d expected 1 at 26", done_pulses, done_idx); end
    tests++; if (wr_cnt != rd_cnt) begin fails++; $display("FAIL single_empty: fill %0d expected 0", wr_cnt - rd_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] got;
    int gap;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    capture(120, -1);
    for (int k = 0; k < 4; k++) begin
      got = decode(2 + 27 * k);
      tests++; if (got !== 4'(k + 1) || tx_log[2 + 27 * k] !== 1'b0) begin
        fails++; $display("FAIL b2b_word%0d: got %h expected %h", k, got, k + 1);
      end
    end
    for (int k = 0; k < 3; k++) begin
      gap = run_high(2 + 27 * k + 20);
      tests++; if (gap !== 7) begin fails++; $display("FAIL b2b_gap%0d: high %0d expected 7", k, gap); end
    end
    tests++; if (rd_pulses !== 4)   begin fails++; $display("FAIL b2b_rd_en: pulses %0d expected 4", rd_pulses); end
    tests++; if (done_pulses !== 4) begin fails++; $display("FAIL b2b_done: pulses %0d expected 4", done_pulses); end
    tests++; if (rd_double !== 1'b0 || underflow !== 1'b0) begin
      fails++; $display("FAIL b2b_pop_rules: double %b underflow %b expected 0 0", rd_double, underflow);
    end
  endtask

  task automatic test_enable_gating;
    logic [3:0] got;
    en = 1'b0;
    push(4'h5); push(4'h3);
    capture(50, -1);
    tests++; if (rd_pulses !== 0 || tx_low !== 0) begin
      fails++; $display("FAIL gate_hold: pulses %0d low %0d expected 0 0", rd_pulses, tx_low);
    end
    en = 1'b1;
    capture(60, 10);
    got = decode(2);
    tests++; if (got !== 4'h5)      begin fails++; $display("FAIL gate_word: got %h expected 5", got); end
    tests++; if (rd_pulses !== 1)   begin fails++; $display("FAIL gate_rd_en: pulses %0d expected 1", rd_pulses); end
    tests++; if (done_pulses !== 1 || tx_low !== 12) begin
      fails++; $display("FAIL gate_one_frame: done %0d low %0d expected 1 12", done_pulses, tx_low);
    end
    tests++; if ((wr_cnt - rd_cnt) !== 1) begin fails++; $display("FAIL gate_fill: fill %0d expected 1", wr_cnt - rd_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] got;
    push(4'h9);
    en = 1'b1;
    capture(16, -1);
    tests++; if (tx_log[15] !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL midrst_pre: tx %b busy %b expected 0 1", tx_log[15], busy);
    end
    #2 rst = 1'b0;
    #1;
    tests++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin
      fails++; $display("FAIL midrst_async: tx %b busy %b rd %b done %b expected 1 0 0 0", tx, busy, fifo_rd_en, frame_done);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    capture(40, -1);
    got = decode(2);
    tests++; if (got !== 4'h9 || tx_log[2] !== 1'b0) begin fails++; $display("FAIL midrst_next: got %h expected 9", got); end
    tests++; if (rd_pulses !== 1 || wr_cnt != rd_cnt) begin
      fails++; $display("FAIL midrst_pops: pulses %0d fill %0d expected 1 0", rd_pulses, wr_cnt - rd_cnt);
    end
  endtask

  task automatic test_empty;
    en = 1'b1;
    capture(100, -1);
    tests++; if (rd_pulses !== 0 || underflow !== 1'b0 || tx_low !== 0 || busy_cyc !== 0) begin
      fails++; $display("FAIL empty_idle: pulses %0d underflow %b low %0d busy %0d expected 0 0 0 0",
                        rd_pulses, underflow, tx_low, busy_cyc);
    end
  endtask

  task automatic test_one_clk_bit;
    logic       log1 [0:15];
    logic [5:0] obs;
    int         b_cnt, r_cnt, d_idx;
    b_cnt = 0; r_cnt = 0; d_idx = -1;
    word1 = 4'hF; wr1 = 1; en1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      log1[i] = tx1;
      if (busy1) b_cnt++;
      if (rd1) r_cnt++;
      if (done1 && d_idx < 0) d_idx = i;
    end
    for (int k = 0; k < 6; k++) obs[k] = log1[2 + k];
    tests++; if (obs !== 6'b111110 || log1[1] !== 1'b1 || log1[8] !== 1'b1) begin
      fails++; $display("FAIL c1_frame: tx %b expected 111110", obs);
    end
    tests++; if (b_cnt !== 8 || d_idx !== 8 || r_cnt !== 1) begin
      fails++; $display("FAIL c1_timing: busy %0d done_at %0d pops %0d expected 8 8 1", b_cnt, d_idx, r_cnt);
    end
    en1 = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; en1 = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_enable_gating();
    test_reset_mid_frame();
    test_empty();
    test_one_clk_bit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
Name: fifo_serial_tx

Overview:
- Downstream drain stage for the register-based FIFO: pops one W-bit word at a time and transmits it as an asynchronous serial frame (start bit, W data bits LSB-first, stop bit).
- Sits between the FIFO read port (rd_en/dout/empty) and an external single-wire line.
- Throttled only by its own bit timing; the FIFO absorbs bursts.

Parameters:
- W, 4, data word width; must match the FIFO W; W >= 1.
- CLKS_PER_BIT, 4, clock cycles per serial bit; CLKS_PER_BIT >= 1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- en  input  1  transmit enable; a new word is popped only while en=1.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  W  FIFO read data; updates at the edge that samples fifo_rd_en=1.
- fifo_rd_en  output  1  FIFO pop strobe, registered, one cycle per word.
- tx  output  1  serial line, registered, idle high.
- busy  output  1  high from the pop cycle through the last stop-bit cycle.
- frame_done  output  1  one-cycle pulse after each completed frame.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, fifo_rd_en=0, busy=0, frame_done=0, counters=0, shift register=0. Takes effect immediately, including mid-frame. A partially sent word is discarded, not re-sent.
- States: IDLE, RD, CAP, START, DATA, STOP.
- IDLE: tx=1, busy=0.
  - If en=1 and fifo_empty=0 at the edge -> RD.
  - Otherwise remain in IDLE.
- RD: fifo_rd_en=1 for exactly this one cycle; busy=1. Next edge -> CAP; the FIFO pops at that edge.
- CAP: fifo_rd_en=0. Next edge captures fifo_dout into the shift register -> START.
- START: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx=shift[0]; bit index 0..W-1, each bit held CLKS_PER_BIT cycles; shift right between bits. After bit W-1 -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE.
  - frame_done=1 for the first IDLE cycle only.
  - busy=0 from that cycle onward.
- Latency: counting the IDLE edge that samples en&&!fifo_empty as edge 1, tx falls after edge 3.
- Frame length: (W+2)*CLKS_PER_BIT cycles of tx activity. Minimum inter-frame tx-high gap beyond the stop bit is 3 cycles (IDLE, RD, CAP).
- en is sampled only in IDLE. Deasserting en mid-frame lets the current frame complete; no further pop follows.
- fifo_empty is sampled only in IDLE. fifo_rd_en is never asserted while the sampled fifo_empty=1, so the FIFO is never under-read.
- Never more than one word in flight; fifo_rd_en never high on two consecutive cycles.
- Counter widths: bit-period counter $clog2(CLKS_PER_BIT+1), bit index $clog2(W+1). Counters reset to 0 on each state entry. CLKS_PER_BIT=1 must work (each bit one cycle).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold rst=0 with FIFO non-empty and en=1 -> tx=1, fifo_rd_en=0, busy=0, frame_done=0 throughout; no pop occurs.
- Single word: write 4'hA, en=1, W=4, CLKS_PER_BIT=4 ->
  - one fifo_rd_en pulse;
  - tx = 0,0,1,0,1,1 (start, bits LSB-first, stop), each level 4 cycles, 24 cycles total;
  - busy high 26 cycles;
  - one frame_done pulse; FIFO empty afterward.
- Back-to-back: fill FIFO with 1,2,3,4, en=1 ->
  - four frames decoding 1,2,3,4 in order;
  - exactly 4 fifo_rd_en pulses;
  - tx high exactly 4+3 cycles between consecutive start bits' preceding stop bits;
  - 4 frame_done pulses; never popped when empty.
- Enable gating:
  - FIFO holding 2 words, en=0 -> no pops, tx=1 indefinitely.
  - Raise en -> first frame starts; drop en during its DATA state -> frame completes, second word stays in FIFO (fill_count=1).
- Reset mid-frame: assert rst=0 during bit 2 of DATA -> tx=1 and busy=0 immediately, without waiting for a clock edge. After release with the FIFO non-empty, the next frame carries the next FIFO word.
- Empty/edge: CLKS_PER_BIT=1 with 4'hF -> 6-cycle frame 0,1,1,1,1,1. FIFO empty with en=1 -> fifo_rd_en stays 0 for 100 cycles.
